div_sequencer: RTL and testbench

//  Iterative multi-cycle divide/remainder engine and controller for M-extension ops 6'b100011..6'b101011
//  (div/divu/rem/remu, divw/divuw/remw/remuw; mulw 6'b100111 is not handled). Sits beside the execute-stage ALU.

---
 rtl/div_sequencer_pkg.sv | 30 +++
 rtl/div_sequencer_if.sv | 19 +
 rtl/div_sequencer_step.sv | 17 +
 rtl/div_sequencer.sv | 127 ++++++++++++
 tb/tb_div_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/div_sequencer_pkg.sv
// Op encodings, FSM state type and op-class helpers for the iterative divider.
package div_pkg;
  localparam logic [5:0] OP_DIV   = 6'b100011;
  localparam logic [5:0] OP_DIVU  = 6'b100100;
  localparam logic [5:0] OP_REM   = 6'b100101;
  localparam logic [5:0] OP_REMU  = 6'b100110;
  localparam logic [5:0] OP_MULW  = 6'b100111;
  localparam logic [5:0] OP_DIVW  = 6'b101000;
  localparam logic [5:0] OP_DIVUW = 6'b101001;
  localparam logic [5:0] OP_REMW  = 6'b101010;
  localparam logic [5:0] OP_REMUW = 6'b101011;

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} div_state_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op >= OP_DIV) && (op <= OP_REMUW) && (op != OP_MULW);
  endfunction

  function automatic logic is_w_op(input logic [5:0] op);
    return op inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_signed_op(input logic [5:0] op);
    return op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction

  function automatic logic is_rem_op(input logic [5:0] op);
    return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction
endpackage

// File: rtl/div_sequencer_if.sv
// EX-stage <-> divider handshake bundle; master is the pipeline, slave the divider.
interface div_sequencer_if #(parameter int DW = 64);
  logic          in_valid;
  logic [5:0]    in_op;
  logic [DW-1:0] in_data1;
  logic [DW-1:0] in_data2;
  logic          in_hold;
  logic          in_flush;
  logic          in_ack;
  logic          out_ready;
  logic          out_stall;
  logic          out_valid;
  logic [DW-1:0] out_result;

  modport master (output in_valid, in_op, in_data1, in_data2, in_hold, in_flush, in_ack,
                  input  out_ready, out_stall, out_valid, out_result);
  modport slave  (input  in_valid, in_op, in_data1, in_data2, in_hold, in_flush, in_ack,
                  output out_ready, out_stall, out_valid, out_result);
endinterface

// File: rtl/div_sequencer_step.sv
// One restoring-division iteration: shift rem:quot left, trial-subtract divisor.
module div_step #(parameter int DW = 64) (
  input  logic [DW-1:0] i_rem,
  input  logic [DW-1:0] i_quot,
  input  logic [DW-1:0] i_dvs,
  output logic [DW-1:0] o_rem,
  output logic [DW-1:0] o_quot
);
  // One extra bit: the shifted remainder can exceed DW bits before subtracting.
  logic [DW:0] w_sh;
  logic        w_ge;

  assign w_sh   = {i_rem, i_quot[DW-1]};
  assign w_ge   = (w_sh >= {1'b0, i_dvs});
  assign o_rem  = w_ge ? DW'(w_sh - {1'b0, i_dvs}) : w_sh[DW-1:0];
  assign o_quot = {i_quot[DW-2:0], w_ge};
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle div/rem controller: latches one op, stalls EX while iterating, holds result until ack.
module div_sequencer
  import div_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int W_WIDTH        = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  div_sequencer_if.slave  bus
);
  localparam int DW = BUS_DATA_WIDTH;
  localparam int WW = W_WIDTH;
  localparam int XW = DW - WW;
  localparam logic [5:0] LAST_X = 6'(DW - 1);
  localparam logic [5:0] LAST_W = 6'(WW - 1);

  div_state_t    r_state;
  logic [5:0]    r_cnt, r_op;
  logic [DW-1:0] r_a, r_b, r_dvs, r_rem, r_quot, r_result;
  logic          r_w, r_sa, r_sb, r_skip;

  logic          w_legal, w_sgn, w_wop, w_a_neg, w_b_neg, w_div0, w_ovf;
  logic [DW-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min, w_q_init;
  logic [DW-1:0] w_q_fix, w_r_fix, w_sel, w_res, w_step_rem, w_step_quot;

  assign w_legal = is_legal_op(bus.in_op);
  assign w_sgn   = is_signed_op(r_op);
  assign w_wop   = is_w_op(r_op);

  // Operands widened to DW per signedness so one datapath serves both widths.
  assign w_a_ext = !w_wop ? r_a : w_sgn ? {{XW{r_a[WW-1]}}, r_a[WW-1:0]} : {{XW{1'b0}}, r_a[WW-1:0]};
  assign w_b_ext = !w_wop ? r_b : w_sgn ? {{XW{r_b[WW-1]}}, r_b[WW-1:0]} : {{XW{1'b0}}, r_b[WW-1:0]};
  assign w_a_neg = w_sgn & w_a_ext[DW-1];
  assign w_b_neg = w_sgn & w_b_ext[DW-1];
  assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
  assign w_min   = w_wop ? {{(XW+1){1'b1}}, {(WW-1){1'b0}}} : {1'b1, {(DW-1){1'b0}}};
  assign w_div0  = (w_b_ext == '0);
  assign w_ovf   = w_sgn && (w_a_ext == w_min) && (w_b_ext == '1);
  // Narrow dividend sits in the top half so WW shifts feed exactly its bits into rem.
  assign w_q_init = w_wop ? {w_a_mag[WW-1:0], {XW{1'b0}}} : w_a_mag;

  div_step #(.DW(DW)) u_step (
    .i_rem  (r_rem),
    .i_quot (r_quot),
    .i_dvs  (r_dvs),
    .o_rem  (w_step_rem),
    .o_quot (w_step_quot)
  );

  assign w_q_fix = (!r_skip && (r_sa ^ r_sb)) ? -r_quot : r_quot;
  assign w_r_fix = (!r_skip && r_sa) ? -r_rem : r_rem;
  assign w_sel   = is_rem_op(r_op) ? w_r_fix : w_q_fix;
  assign w_res   = r_w ? {{XW{w_sel[WW-1]}}, w_sel[WW-1:0]} : w_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_result <= '0;
      r_w      <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_skip   <= 1'b0;
    end else if (!bus.in_hold) begin
      if (bus.in_flush) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: if (bus.in_valid && w_legal) begin
            r_op    <= bus.in_op;
            r_a     <= bus.in_data1;
            r_b     <= bus.in_data2;
            r_state <= PREP;
          end
          PREP: begin
            r_w    <= w_wop;
            r_sa   <= w_a_neg;
            r_sb   <= w_b_neg;
            r_dvs  <= w_b_mag;
            r_cnt  <= '0;
            r_skip <= w_div0 | w_ovf;
            if (w_div0) begin
              r_quot  <= '1;
              r_rem   <= w_a_ext;
              r_state <= FIX;
            end else if (w_ovf) begin
              r_quot  <= w_a_ext;
              r_rem   <= '0;
              r_state <= FIX;
            end else begin
              r_quot  <= w_q_init;
              r_rem   <= '0;
              r_state <= RUN;
            end
          end
          RUN: begin
            r_rem  <= w_step_rem;
            r_quot <= w_step_quot;
            if (r_cnt == (r_w ? LAST_W : LAST_X)) r_state <= FIX;
            else                                  r_cnt   <= r_cnt + 6'd1;
          end
          FIX: begin
            r_result <= w_res;
            r_state  <= DONE;
          end
          DONE:    if (bus.in_ack) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.out_ready  = (r_state == IDLE);
  assign bus.out_valid  = (r_state == DONE);
  assign bus.out_result = r_result;
  assign bus.out_stall  = (r_state == IDLE && bus.in_valid && w_legal) ||
                          (r_state == PREP) || (r_state == RUN) || (r_state == FIX);
endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboarded bench for div_sequencer: directed spec cases, random ops, hold/flush/reset.
module tb_div_sequencer;
  import div_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  div_sequencer_if u_if();

  div_sequencer #(.BUS_DATA_WIDTH(64), .W_WIDTH(32)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];
  logic [5:0]  ops[8] = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
    logic w, sg, rm;
    logic signed [63:0] sa64, sb64;
    logic signed [31:0] sa32, sb32;
    logic [63:0] q, r;
    logic [31:0] q32, r32, x32;
    w  = op inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    sg = op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    rm = op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    if (w) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      if (b[31:0] == 32'd0) begin q32 = 32'hFFFF_FFFF; r32 = a[31:0]; end
      else if (sg && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin q32 = a[31:0]; r32 = 32'd0; end
      else if (sg) begin q32 = sa32 / sb32; r32 = sa32 % sb32; end
      else begin q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0]; end
      x32 = rm ? r32 : q32;
      return {{32{x32[31]}}, x32};
    end
    sa64 = a;
    sb64 = b;
    if (b == 64'd0) begin q = '1; r = a; end
    else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 64'd0; end
    else if (sg) begin q = sa64 / sb64; r = sa64 % sb64; end
    else begin q = a / b; r = a % b; end
    return rm ? r : q;
  endfunction

  function automatic int exp_latency(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
    logic w, sg;
    w  = op inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    sg = op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    if (w) begin
      if (b[31:0] == 0 || (sg && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)) return 2;
      return 34;
    end
    if (b == 0 || (sg && a == 64'h8000_0000_0000_0000 && b == '1)) return 2;
    return 66;
  endfunction

  task automatic run_op(input string tag, input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int hold_at, input int flush_at);
    int lat;
    int exp_lat;
    logic stall_ok, seen;
    logic [63:0] exp;
    exp_lat = exp_latency(op, a, b) + ((hold_at > 0) ? 5 : 0);
    @(negedge clk);
    u_if.in_valid = 1'b1;
    u_if.in_op    = op;
    u_if.in_data1 = a;
    u_if.in_data2 = b;
    #1;
    chk({tag, "_stall_req"}, 64'(u_if.out_stall), 64'd1);
    if (flush_at == 0) sb_q.push_back(model(op, a, b));
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    lat = 0;
    stall_ok = 1'b1;
    while (1) begin
      @(posedge clk); lat++; #1;
      if (flush_at > 0 && lat == flush_at + 1) begin u_if.in_flush = 1'b0; break; end
      if (u_if.out_valid) break;
      if (!u_if.out_stall) stall_ok = 1'b0;
      if (hold_at > 0 && lat == hold_at)     u_if.in_hold = 1'b1;
      if (hold_at > 0 && lat == hold_at + 5) u_if.in_hold = 1'b0;
      if (flush_at > 0 && lat == flush_at)   u_if.in_flush = 1'b1;
      if (lat >= 200) break;
    end
    if (flush_at > 0) begin
      chk({tag, "_flush_ready"}, 64'(u_if.out_ready), 64'd1);
      chk({tag, "_flush_stall"}, 64'(u_if.out_stall), 64'd0);
      seen = u_if.out_valid;
      repeat (80) begin
        @(posedge clk); #1;
        if (u_if.out_valid) seen = 1'b1;
      end
      chk({tag, "_flush_novalid"}, 64'(seen), 64'd0);
      return;
    end
    if (!u_if.out_valid) begin
      chk({tag, "_timeout"}, 64'(u_if.out_valid), 64'd1);
      void'(sb_q.pop_front());
      return;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
    chk({tag, "_stall_done"}, 64'(u_if.out_stall), 64'd0);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    exp = sb_q.pop_front();
    chk({tag, "_result"}, u_if.out_result, exp);
    u_if.in_ack = 1'b1;
    @(posedge clk); #1;
    u_if.in_ack = 1'b0;
    chk({tag, "_ack_ready"}, 64'(u_if.out_ready), 64'd1);
    chk({tag, "_ack_hold"}, u_if.out_result, exp);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [5:0]  rop;
    u_if.in_valid = 1'b0; u_if.in_op = '0; u_if.in_data1 = '0; u_if.in_data2 = '0;
    u_if.in_hold = 1'b0;  u_if.in_flush = 1'b0; u_if.in_ack = 1'b0;
    #12;
    chk("rst_ready",  64'(u_if.out_ready), 64'd1);
    chk("rst_stall",  64'(u_if.out_stall), 64'd0);
    chk("rst_valid",  64'(u_if.out_valid), 64'd0);
    chk("rst_result", u_if.out_result, 64'd0);
    @(negedge clk); reset_n = 1'b1;

    // mulw is not ours: no stall, no accept
    @(negedge clk);
    u_if.in_valid = 1'b1; u_if.in_op = OP_MULW; u_if.in_data1 = 64'd3; u_if.in_data2 = 64'd4;
    #1 chk("mulw_stall", 64'(u_if.out_stall), 64'd0);
    @(posedge clk); #1;
    chk("mulw_ready", 64'(u_if.out_ready), 64'd1);
    u_if.in_valid = 1'b0;

    run_op("divu_100_7",  OP_DIVU, 64'd100, 64'd7, 0, 0);
    run_op("div_m7_2",    OP_DIV,  -64'sd7, 64'd2, 0, 0);
    run_op("rem_m7_2",    OP_REM,  -64'sd7, 64'd2, 0, 0);
    run_op("remu_max_10", OP_REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 0, 0);
    run_op("div_5_0",     OP_DIV,  64'd5, 64'd0, 0, 0);
    run_op("rem_5_0",     OP_REM,  64'd5, 64'd0, 0, 0);
    run_op("div_ovf",     OP_DIV,  64'h8000_0000_0000_0000, '1, 0, 0);
    run_op("remw_ovf",    OP_REMW, 64'h0000_0000_8000_0000, '1, 0, 0);
    run_op("divw_sext",   OP_DIVW, 64'h0000_0001_8000_0000, 64'd1, 0, 0);
    run_op("divuw_0",     OP_DIVUW, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 0, 0);
    run_op("remuw_big",   OP_REMUW, 64'h0000_0000_FFFF_FFFF, 64'd7, 0, 0);

    for (int i = 0; i < 8; i++) begin
      rop = ops[$urandom_range(7)];
      ra  = {$urandom, $urandom};
      rb  = (i < 4) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
      if (i[0]) ra = -ra;
      run_op($sformatf("rand%0d", i), rop, ra, rb, 0, 0);
    end

    run_op("hold5",  OP_DIVU, 64'd1000, 64'd3, 10, 0);
    run_op("flush",  OP_DIV,  64'd12345, 64'd67, 0, 11);

    // asynchronous reset in the middle of an iteration
    @(negedge clk);
    u_if.in_valid = 1'b1; u_if.in_op = OP_DIVU; u_if.in_data1 = 64'd999; u_if.in_data2 = 64'd9;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("amid_ready",  64'(u_if.out_ready), 64'd1);
    chk("amid_stall",  64'(u_if.out_stall), 64'd0);
    chk("amid_valid",  64'(u_if.out_valid), 64'd0);
    chk("amid_result", u_if.out_result, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    run_op("post_rst", OP_REMU, 64'd50, 64'd8, 0, 0);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
